// File: rtl/exposure_sequencer.sv
// rtl/exposure_sequencer.sv - erase/expose/two-row readout capture sequencer; optional EXP_CLAMP_EN clamps exposure to [EXP_MIN, EXP_MAX]
module exposure_sequencer #(
  parameter int EXP_W           = 5,
  parameter int EXP_MIN         = 2,
  parameter int EXP_MAX         = 30,
  parameter int CYCLES_PER_UNIT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic [EXP_W-1:0] Exp_time,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy
);

`ifdef EXP_CLAMP_EN
  localparam int CNT_W = $clog2(EXP_MAX * CYCLES_PER_UNIT + 1);
`else
  localparam int CNT_W = $clog2((2**EXP_W - 1) * CYCLES_PER_UNIT + 1);
`endif

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXPOSE  = 2'd1;
  localparam logic [1:0] ST_READOUT = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       phase;
  logic [EXP_W-1:0] e_sel;
  logic [CNT_W-1:0] load_val;

  // Readout strobes for phase q, packed as {NRE_1, NRE_2, ADC}; the two row
  // enables are separated by one all-inactive step so they never overlap.
  function automatic logic [2:0] strobes(input logic [2:0] q);
    case (q)
      3'd0:    strobes = 3'b010;
      3'd1:    strobes = 3'b011;
      3'd2:    strobes = 3'b010;
      3'd4:    strobes = 3'b100;
      3'd5:    strobes = 3'b101;
      3'd6:    strobes = 3'b100;
      default: strobes = 3'b110;
    endcase
  endfunction

  // Effective exposure and counter load value (product formed at counter width)
  always_comb begin
    e_sel = Exp_time;
`ifdef EXP_CLAMP_EN
    if (Exp_time < EXP_W'(EXP_MIN)) begin
      e_sel = EXP_W'(EXP_MIN);
    end else if (Exp_time > EXP_W'(EXP_MAX)) begin
      e_sel = EXP_W'(EXP_MAX);
    end
`else
    if (Exp_time == '0) begin
      e_sel = EXP_W'(1);
    end
`endif
    load_val = CNT_W'(e_sel) * CNT_W'(CYCLES_PER_UNIT);
  end

  // Capture state machine with registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      phase  <= '0;
      Erase  <= 1'b1;
      Expose <= 1'b0;
      NRE_1  <= 1'b1;
      NRE_2  <= 1'b1;
      ADC    <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Init) begin
            state  <= ST_EXPOSE;
            cnt    <= load_val;
            Erase  <= 1'b0;
            Expose <= 1'b1;
            Busy   <= 1'b1;
          end
        end
        ST_EXPOSE: begin
          if (cnt == CNT_W'(1)) begin
            state                <= ST_READOUT;
            cnt                  <= '0;
            phase                <= 3'd0;
            Expose               <= 1'b0;
            {NRE_1, NRE_2, ADC}  <= strobes(3'd0);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_READOUT: begin
          if (phase == 3'd7) begin
            state               <= ST_IDLE;
            phase               <= 3'd0;
            Erase               <= 1'b1;
            Busy                <= 1'b0;
            {NRE_1, NRE_2, ADC} <= 3'b110;
          end else begin
            phase               <= phase + 3'd1;
            {NRE_1, NRE_2, ADC} <= strobes(phase + 3'd1);
          end
        end
        default: begin
          state               <= ST_IDLE;
          cnt                 <= '0;
          phase               <= '0;
          Erase               <= 1'b1;
          Expose              <= 1'b0;
          Busy                <= 1'b0;
          {NRE_1, NRE_2, ADC} <= 3'b110;
        end
      endcase
    end
  end

endmodule
